// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns
// (bit 6..0, active-high), the blank pattern and the scan state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1110111;
  localparam logic [6:0] SEG_1 = 7'b0100100;
  localparam logic [6:0] SEG_2 = 7'b1011101;
  localparam logic [6:0] SEG_3 = 7'b1101101;
  localparam logic [6:0] SEG_4 = 7'b0101110;
  localparam logic [6:0] SEG_5 = 7'b1101011;
  localparam logic [6:0] SEG_6 = 7'b1111011;
  localparam logic [6:0] SEG_7 = 7'b0100101;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b0111111;
  localparam logic [6:0] SEG_B = 7'b1111010;
  localparam logic [6:0] SEG_C = 7'b1010011;
  localparam logic [6:0] SEG_D = 7'b1111100;
  localparam logic [6:0] SEG_E = 7'b1011011;
  localparam logic [6:0] SEG_F = 7'b0011011;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_DEAD
  } scan_state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered display word.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DWELL    = 4,
  parameter int DEAD     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic [N_DIGITS-1:0]     digit_sel,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL > DEAD) ? DWELL : DEAD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  scan_state_t r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next, w_idx_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [4*N_DIGITS-1:0] r_act_data, w_act_data_next, r_pend_data, w_pend_data_next;
  logic [N_DIGITS-1:0] r_act_blank, w_act_blank_next, r_pend_blank, w_pend_blank_next;
  logic r_pend_valid, w_pend_valid_next;
  logic [N_DIGITS-1:0] r_digit_sel, w_sel_next, w_lz_mask, w_blank_eff;
  logic [6:0] r_seg, w_seg_next, w_dec;
  logic [3:0] w_nib;
  logic r_frame_done, w_fd_next;

  assign w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_next = ST_SHOW;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end else if (r_cnt == DWELL_LAST) begin
          w_cnt_next = '0;
          if (DEAD > 0) begin
            w_state_next = ST_DEAD;
          end else begin
            w_idx_next = w_idx_inc;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DEAD: begin
        if (!en) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end else if (r_cnt == DEAD_LAST) begin
          w_state_next = ST_SHOW;
          w_idx_next   = w_idx_inc;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // frame_done is registered, so flag the upcoming cycle if it closes the last digit
  always_comb begin
    w_fd_next = 1'b0;
    if (w_idx_next == IDX_LAST) begin
      if (DEAD > 0)
        w_fd_next = (w_state_next == ST_DEAD) && (w_cnt_next == DEAD_LAST);
      else
        w_fd_next = (w_state_next == ST_SHOW) && (w_cnt_next == DWELL_LAST);
    end
  end

  always_comb begin
    w_act_data_next   = r_act_data;
    w_act_blank_next  = r_act_blank;
    w_pend_data_next  = r_pend_data;
    w_pend_blank_next = r_pend_blank;
    w_pend_valid_next = r_pend_valid;
    if ((r_frame_done || (r_state == ST_IDLE && en)) && r_pend_valid) begin
      w_act_data_next   = r_pend_data;
      w_act_blank_next  = r_pend_blank;
      w_pend_valid_next = 1'b0;
    end
    if (load) begin
      if (r_frame_done) begin
        w_act_data_next  = data_in;
        w_act_blank_next = blank_in;
      end else begin
        w_pend_data_next  = data_in;
        w_pend_blank_next = blank_in;
        w_pend_valid_next = 1'b1;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic w_nz_seen;
    w_nz_seen = 1'b0;
    w_lz_mask = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      w_nz_seen    = w_nz_seen | (w_act_data_next[4*i +: 4] != 4'h0);
      w_lz_mask[i] = ~w_nz_seen;
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  assign w_blank_eff = w_act_blank_next | w_lz_mask;
  assign w_nib       = w_act_data_next[4*w_idx_next +: 4];

  hex_seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  assign w_sel_next = (w_state_next == ST_SHOW) ? (N_DIGITS'(1) << w_idx_next) : '0;
  assign w_seg_next = (w_state_next == ST_SHOW && !w_blank_eff[w_idx_next]) ? w_dec : SEG_BLANK;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '0;
      r_pend_data  <= '0;
      r_pend_blank <= '0;
      r_pend_valid <= 1'b0;
      r_digit_sel  <= '0;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_act_data   <= w_act_data_next;
      r_act_blank  <= w_act_blank_next;
      r_pend_data  <= w_pend_data_next;
      r_pend_blank <= w_pend_blank_next;
      r_pend_valid <= w_pend_valid_next;
      r_digit_sel  <= w_sel_next;
      r_seg        <= w_seg_next;
      r_frame_done <= w_fd_next;
    end
  end

  assign digit_sel  = r_digit_sel;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-select 7-segment digits. It holds a double-buffered hex word and cycles a one-hot digit select across the bank, with a programmable dwell and dead-time per digit. It drives each digit's segment pattern through a nibble-to-segment decoder. It sits between the register/bus side, which loads values, and the board-level digit drivers.

## Interface
- `N_DIGITS`, 4, number of digits scanned (1..8)
- `DWELL`, 4, cycles each digit is lit (≥1)
- `DEAD`, 1, blanking cycles after each digit (≥0; 0 = no dead-time)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: scan enable
- `load` in 1: write strobe for `data_in`/`blank_in`
- `data_in` in 4*N_DIGITS: hex nibbles; digit i = bits [4i+3:4i]
- `blank_in` in N_DIGITS: bit i = 1 forces digit i dark
- `digit_sel` out N_DIGITS: one-hot active-high digit enable
- `seg` out 7: segment pattern, bit 6..0, active-high
- `frame_done` out 1: one-cycle pulse at the end of each full scan

## Operation
- Reset: `digit_sel`=0, `seg`=0, `frame_done`=0, state IDLE, index=0, counters=0, active and pending buffers=0, pending_valid=0.
- States:
  - IDLE: outputs 0. `en`=1 → SHOW(index 0); on that transition active←pending if pending_valid.
  - SHOW: `digit_sel`=1<<index; `seg`=decode(active nibble), or 0 if the blank bit is set. Lasts exactly DWELL cycles, then goes to DEAD, or straight to the next digit if DEAD=0.
  - DEAD: `digit_sel`=0, `seg`=0 for DEAD cycles, then index+1 → SHOW.
- Wrap: after digit N_DIGITS-1 completes (its DEAD, or its SHOW if DEAD=0), index wraps to 0. `frame_done` is high during that final cycle.
- Frame boundary: in the `frame_done` cycle, active←pending if pending_valid, and pending_valid clears. If `load`=1 in that same cycle, `data_in`/`blank_in` go directly to active (load wins).
- `load` in any other cycle: pending←`data_in`/`blank_in`, pending_valid=1. A later load overwrites pending. The displayed frame never changes mid-scan, so there is no tearing.
- `en`=0 in SHOW/DEAD: go to IDLE next cycle. Outputs are 0, index and counters reset, pending is preserved, and `frame_done` does not pulse.
- `rst` overrides everything in any state.
- Decode, hex→bit6..0:
  - 0 1110111, 1 0100100, 2 1011101, 3 1101101
  - 4 0101110, 5 1101011, 6 1111011, 7 0100101
  - 8 1111111, 9 1101111, A 0111111, b 1111010
  - C 1010011, d 1111100, E 1011011, F 0011011

## Timing
- `digit_sel`, `seg` and `frame_done` are registered. The first digit-0 cycle is the cycle after the edge where `en` is first sampled high in IDLE.
- Frame period = N_DIGITS*(DWELL+DEAD) cycles; no idle cycles between frames while `en`=1.
- Load-to-display latency: at most one frame period plus one cycle.
- Dwell and dead counters use width clog2(max(DWELL,DEAD)+1). Index width is clog2(N_DIGITS), wrapping explicitly at N_DIGITS-1.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined:
  - Scanning from digit N_DIGITS-1 downward, each zero nibble is blanked until the first non-zero nibble.
  - Digit 0 is never blanked by this rule.
  - The result is ORed with the blank mask and computed from the active buffer at each frame boundary.
- Undefined: zeros display normally; only the blank mask darkens digits.

## Structure
- Package `seg_pkg`: the 16 segment-pattern constants, the blank pattern (7'b0), and the state enum (IDLE/SHOW/DEAD).
- Sub-module `hex_seg_decode`: combinational nibble→7-bit decoder using the patterns above.
- The top level holds the FSM, counters and double buffer.

## Test plan
- **Basic scan:** N=4, DWELL=4, DEAD=1; rst, load 16'h1234, en=1 → `digit_sel`=0001 and `seg`=0101110 for 4 cycles, then 1 cycle of 0/0, then 0010 with `seg`=1101101. `frame_done` pulses every 20 cycles.
- **Mid-frame load:** load 16'hABCD during digit 1 → the current frame still shows 1234; the first digit-0 after `frame_done` shows `seg`=1111100.
- **Load on boundary:** load 16'h0F0F in the `frame_done` cycle → the next frame shows digit0 `seg`=0011011 and digit1 `seg`=1110111.
- **Blank mask:** `blank_in`=4'b1000 → `digit_sel`=1000 is still asserted for 4 cycles with `seg`=0.
- **Enable drop:** `en`=0 during digit 2 → next cycle `digit_sel`=0, `seg`=0, no `frame_done`. Re-enable → digit 0 is lit the cycle after.
- **Macro defined:** data 16'h0050 → digits 3 and 2 have `seg`=0, digit 1 shows 1101011, digit 0 shows 1110111. Data 16'h0000 → only digit 0 is lit, with 1110111.
